// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with a valid/ack holding register
// reporting parity, framing and overrun status for each delivered frame.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_EN  = 1,
    parameter bit PARITY_ODD = 0
) (
    input  logic                  uart_clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic                  rx_ack,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  rx_busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t                state, state_n;
    logic                  rx_meta, rx_s, sample, done, par_bit, par_bad, stop_bad;
    logic [TW-1:0]         tick;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg;

    always_comb begin
        state_n = state;
        sample  = (state == START) ? (tick == HALF) : (state inside {DATA, PARITY, STOP}) && (tick == FULL);
        case (state)
            IDLE:    state_n = rx_s ? IDLE : START;
            START:   state_n = !sample ? START : rx_s ? IDLE : DATA;
            DATA:    state_n = !(sample && bit_idx == LAST) ? DATA : PARITY_EN ? PARITY : STOP;
            PARITY:  state_n = sample ? STOP : PARITY;
            STOP:    state_n = !sample ? STOP : rx_s ? IDLE : BREAK;
            BREAK:   state_n = rx_s ? IDLE : BREAK;
            default: state_n = IDLE;
        endcase
    end

    // done is the registered frame-complete strobe; delivery acts on it one cycle later
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            state    <= IDLE;
            tick     <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_bad <= 1'b0;
            done     <= 1'b0;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            state   <= state_n;
            tick    <= (sample || state_n != state) ? '0 : tick + TW'(1);
            bit_idx <= (state != DATA) ? '0 : bit_idx + BW'(sample);
            if (sample && state == DATA) shreg <= DATA_WIDTH'({rx_s, shreg} >> 1);
            if (sample && state == PARITY) par_bit <= rx_s;
            if (sample && state == STOP) stop_bad <= ~rx_s;
            done <= sample && state == STOP;
        end
    end

    assign par_bad = PARITY_EN && (^shreg ^ par_bit ^ PARITY_ODD);

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (done && (!rx_valid || rx_ack)) begin
            rx_data     <= shreg;
            rx_valid    <= 1'b1;
            parity_err  <= par_bad;
            frame_err   <= stop_bad;
            overrun_err <= 1'b0;
        end else if (done) begin
            overrun_err <= 1'b1;
        end else if (rx_valid && rx_ack) begin
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

    assign rx_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against three receiver configurations
// (even parity, odd parity, and no parity at 8x oversampling).
module tb_uart_rx;
    logic       uart_clk = 1'b0, rst_n = 1'b1, rst2_n = 1'b1;
    logic       rx_in = 1'b1, rx_in2 = 1'b1, rx_ack = 1'b0, rx_ack2 = 1'b0;
    logic [7:0] d0, d1, d2;
    logic       v0, pe0, fe0, oe0, b0, v1, pe1, fe1, oe1, b1, v2, pe2, fe2, oe2, b2;
    int         checks = 0, errors = 0;

    always #5 uart_clk = ~uart_clk;

    uart_rx u0 (.uart_clk(uart_clk), .rst_n(rst_n), .rx_in(rx_in), .rx_ack(rx_ack), .rx_data(d0),
                .rx_valid(v0), .parity_err(pe0), .frame_err(fe0), .overrun_err(oe0), .rx_busy(b0));
    uart_rx #(.PARITY_ODD(1)) u1 (.uart_clk(uart_clk), .rst_n(rst_n), .rx_in(rx_in), .rx_ack(rx_ack), .rx_data(d1),
                .rx_valid(v1), .parity_err(pe1), .frame_err(fe1), .overrun_err(oe1), .rx_busy(b1));
    uart_rx #(.PARITY_EN(0), .OVERSAMPLE(8)) u2 (.uart_clk(uart_clk), .rst_n(rst2_n), .rx_in(rx_in2), .rx_ack(rx_ack2),
                .rx_data(d2), .rx_valid(v2), .parity_err(pe2), .frame_err(fe2), .overrun_err(oe2), .rx_busy(b2));

    // 16x line: start, 8 data LSB first, parity, stop; rx_ack pulses in cycle ack_at
    task automatic send(input logic [7:0] d, input logic par, input logic stop, input int ack_at, input int ncyc);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int c = 0; c < ncyc; c++) begin
            rx_in  = bits[c / 16];
            rx_ack = (c == ack_at);
            @(negedge uart_clk);
        end
        rx_ack = 1'b0;
    endtask

    task automatic send2(input logic [7:0] d, input logic stop, input int ncyc);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int c = 0; c < ncyc; c++) begin
            rx_in2 = bits[c / 8];
            @(negedge uart_clk);
        end
    endtask

    task automatic ack0;
        rx_ack = 1'b1;
        @(negedge uart_clk);
        rx_ack = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        rst2_n = 1'b0;
        repeat (3) @(negedge uart_clk);
        checks++; if ({d0, v0, pe0, fe0, oe0, b0, d1, v1, pe1, fe1, oe1, b1} !== 26'd0) begin errors++; $display("FAIL reset_u01: got %h expected 0", {d0, v0, pe0, fe0, oe0, b0, d1, v1, pe1, fe1, oe1, b1}); end
        checks++; if ({d2, v2, pe2, fe2, oe2, b2} !== 13'd0) begin errors++; $display("FAIL reset_u2: got %h expected 0", {d2, v2, pe2, fe2, oe2, b2}); end
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        repeat (4) @(negedge uart_clk);
    endtask

    task automatic test_basic;
        send(8'hA5, 1'b0, 1'b1, -1, 176);
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", v0); end
        checks++; if (d0 !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", d0); end
        checks++; if ({pe0, fe0, oe0} !== 3'b000) begin errors++; $display("FAIL basic_flags: got %b expected 000", {pe0, fe0, oe0}); end
        repeat (50) @(negedge uart_clk);
        checks++; if (v0 !== 1'b1 || d0 !== 8'hA5) begin errors++; $display("FAIL basic_hold: got v=%b d=%h expected v=1 d=a5", v0, d0); end
        ack0;
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL basic_ack: got %b expected 0", v0); end
    endtask

    task automatic test_parity;
        send(8'h3C, 1'b1, 1'b1, -1, 176);
        checks++; if (d0 !== 8'h3C || pe0 !== 1'b1) begin errors++; $display("FAIL parity_even: got d=%h pe=%b expected d=3c pe=1", d0, pe0); end
        checks++; if (fe0 !== 1'b0) begin errors++; $display("FAIL parity_fe: got %b expected 0", fe0); end
        checks++; if (v1 !== 1'b1 || d1 !== 8'h3C || pe1 !== 1'b0 || fe1 !== 1'b0) begin errors++; $display("FAIL parity_odd: got v=%b d=%h pe=%b fe=%b expected v=1 d=3c pe=0 fe=0", v1, d1, pe1, fe1); end
        ack0;
    endtask

    task automatic test_break;
        int busy_low;
        busy_low = 0;
        send(8'h55, 1'b0, 1'b0, -1, 176);
        checks++; if (v0 !== 1'b1 || d0 !== 8'h55) begin errors++; $display("FAIL break_frame: got v=%b d=%h expected v=1 d=55", v0, d0); end
        checks++; if (fe0 !== 1'b1 || pe0 !== 1'b0) begin errors++; $display("FAIL break_flags: got fe=%b pe=%b expected fe=1 pe=0", fe0, pe0); end
        ack0;
        repeat (640) begin
            @(negedge uart_clk);
            if (!b0) busy_low++;
        end
        checks++; if (busy_low !== 0) begin errors++; $display("FAIL break_busy: got %0d idle cycles expected 0", busy_low); end
        rx_in = 1'b1;
        repeat (32) @(negedge uart_clk);
        checks++; if (b0 !== 1'b0 || v0 !== 1'b0) begin errors++; $display("FAIL break_exit: got busy=%b v=%b expected 0 0", b0, v0); end
        send(8'h12, 1'b0, 1'b1, -1, 176);
        checks++; if (v0 !== 1'b1 || d0 !== 8'h12 || fe0 !== 1'b0) begin errors++; $display("FAIL break_next: got v=%b d=%h fe=%b expected v=1 d=12 fe=0", v0, d0, fe0); end
        ack0;
    endtask

    task automatic test_glitch;
        rx_in = 1'b0;
        repeat (5) @(negedge uart_clk);
        rx_in = 1'b1;
        repeat (40) @(negedge uart_clk);
        checks++; if (v0 !== 1'b0 || b0 !== 1'b0) begin errors++; $display("FAIL glitch_idle: got v=%b busy=%b expected 0 0", v0, b0); end
        send(8'h81, 1'b0, 1'b1, -1, 176);
        checks++; if (v0 !== 1'b1 || d0 !== 8'h81 || pe0 !== 1'b0) begin errors++; $display("FAIL glitch_next: got v=%b d=%h pe=%b expected v=1 d=81 pe=0", v0, d0, pe0); end
        ack0;
    endtask

    task automatic test_back_to_back;
        send(8'h11, 1'b0, 1'b1, -1, 176);
        send(8'h22, 1'b0, 1'b1, -1, 176);
        checks++; if (v0 !== 1'b1 || d0 !== 8'h11) begin errors++; $display("FAIL b2b_data: got v=%b d=%h expected v=1 d=11", v0, d0); end
        checks++; if (oe0 !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b expected 1", oe0); end
        ack0;
        checks++; if (oe0 !== 1'b0 || v0 !== 1'b0) begin errors++; $display("FAIL b2b_ack: got oe=%b v=%b expected 0 0", oe0, v0); end
        send(8'h44, 1'b0, 1'b1, -1, 176);
        checks++; if (v0 !== 1'b1 || d0 !== 8'h44) begin errors++; $display("FAIL b2b_hold: got v=%b d=%h expected v=1 d=44", v0, d0); end
        send(8'h33, 1'b0, 1'b1, 171, 176);
        checks++; if (v0 !== 1'b1 || d0 !== 8'h33 || oe0 !== 1'b0) begin errors++; $display("FAIL b2b_ack_load: got v=%b d=%h oe=%b expected v=1 d=33 oe=0", v0, d0, oe0); end
    endtask

    task automatic test_reset_mid;
        send(8'hF0, 1'b0, 1'b1, -1, 80);
        rst_n = 1'b0;
        #1;
        checks++; if ({d0, v0, pe0, fe0, oe0, b0} !== 13'd0) begin errors++; $display("FAIL rstmid_outputs: got %h expected 0", {d0, v0, pe0, fe0, oe0, b0}); end
        rx_in = 1'b1;
        repeat (3) @(negedge uart_clk);
        rst_n = 1'b1;
        repeat (40) @(negedge uart_clk);
        checks++; if (v0 !== 1'b0 || b0 !== 1'b0) begin errors++; $display("FAIL rstmid_nodeliver: got v=%b busy=%b expected 0 0", v0, b0); end
        send(8'h0F, 1'b0, 1'b1, -1, 176);
        checks++; if (v0 !== 1'b1 || d0 !== 8'h0F || pe0 !== 1'b0) begin errors++; $display("FAIL rstmid_next: got v=%b d=%h pe=%b expected v=1 d=0f pe=0", v0, d0, pe0); end
    endtask

    task automatic test_no_parity;
        send2(8'h3A, 1'b1, 80);
        checks++; if (v2 !== 1'b1 || d2 !== 8'h3A || pe2 !== 1'b0 || fe2 !== 1'b0) begin errors++; $display("FAIL np_frame: got v=%b d=%h pe=%b fe=%b expected v=1 d=3a pe=0 fe=0", v2, d2, pe2, fe2); end
        send2(8'hF0, 1'b1, 40);
        rst2_n = 1'b0;
        #1;
        checks++; if ({d2, v2, pe2, fe2, oe2, b2} !== 13'd0) begin errors++; $display("FAIL np_rstmid: got %h expected 0", {d2, v2, pe2, fe2, oe2, b2}); end
        rx_in2 = 1'b1;
        repeat (3) @(negedge uart_clk);
        rst2_n = 1'b1;
        repeat (20) @(negedge uart_clk);
        checks++; if (v2 !== 1'b0 || b2 !== 1'b0) begin errors++; $display("FAIL np_nodeliver: got v=%b busy=%b expected 0 0", v2, b2); end
        send2(8'h0F, 1'b1, 80);
        checks++; if (v2 !== 1'b1 || d2 !== 8'h0F) begin errors++; $display("FAIL np_next: got v=%b d=%h expected v=1 d=0f", v2, d2); end
        rx_ack2 = 1'b1;
        @(negedge uart_clk);
        rx_ack2 = 1'b0;
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL np_ack: got %b expected 0", v2); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_break;
        test_glitch;
        test_back_to_back;
        test_reset_mid;
        test_no_parity;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
